// File: rtl/combat_arbiter.sv
// Combat resolver between two player attack FSMs: once per frame decides hit/clash,
// owns both hit-stun timers, accumulates damage and drives knockback and event pulses.
module combat_arbiter #(
    parameter int STUN_FRAMES  = 20,
    parameter int CLASH_FRAMES = 6,
    parameter int DMG_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             round_reset,
    input  logic             p1_attack_active,
    input  logic [3:0]       p1_anim_state,
    input  logic             p1_facing,
    input  logic             p2_attack_active,
    input  logic [3:0]       p2_anim_state,
    input  logic             p2_facing,
    input  logic             p1_hits_p2,
    input  logic             p2_hits_p1,
    output logic             p1_hit_stun_active,
    output logic             p2_hit_stun_active,
    output logic [DMG_W-1:0] p1_damage,
    output logic [DMG_W-1:0] p2_damage,
    output logic             p1_kb_dir,
    output logic             p2_kb_dir,
    output logic             hit_event,
    output logic             clash_event
);

    localparam int MAX_FRAMES = (STUN_FRAMES > CLASH_FRAMES) ? STUN_FRAMES : CLASH_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] STUN_LOAD  = CNT_W'(STUN_FRAMES);
    localparam logic [CNT_W-1:0] CLASH_LOAD = CNT_W'(CLASH_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic [DMG_W-1:0] dmg_of(input logic [3:0] anim);
        case (anim)
            4'd6:    return DMG_W'(3);
            4'd7:    return DMG_W'(5);
            4'd8:    return DMG_W'(4);
            4'd9:    return DMG_W'(6);
            default: return DMG_W'(1);
        endcase
    endfunction

    // Damage saturates at all-ones instead of wrapping back to a low value.
    function automatic logic [DMG_W-1:0] sat_add(input logic [DMG_W-1:0] a,
                                                 input logic [DMG_W-1:0] b);
        logic [DMG_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DMG_W] ? {DMG_W{1'b1}} : sum[DMG_W-1:0];
    endfunction

    logic [CNT_W-1:0] p1_stun, p2_stun, p1_stun_nxt, p2_stun_nxt;
    logic             p1_used, p2_used, p1_used_nxt, p2_used_nxt;
    logic [DMG_W-1:0] p1_dmg_nxt, p2_dmg_nxt;
    logic             p1_kb_nxt, p2_kb_nxt, hit_nxt, clash_nxt;
    logic             p1_stunned, p2_stunned, cand_a, cand_b;

    assign p1_stunned = (p1_stun != '0);
    assign p2_stunned = (p2_stun != '0);

    // A stunned player can neither land nor receive a hit, so either stun blocks both candidates.
    assign cand_a = p1_attack_active & p1_hits_p2 & ~p1_used & ~p1_stunned & ~p2_stunned;
    assign cand_b = p2_attack_active & p2_hits_p1 & ~p2_used & ~p1_stunned & ~p2_stunned;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        p1_stun_nxt = p1_stun;
        p2_stun_nxt = p2_stun;
        p1_used_nxt = p1_used;
        p2_used_nxt = p2_used;
        p1_dmg_nxt  = p1_damage;
        p2_dmg_nxt  = p2_damage;
        p1_kb_nxt   = p1_kb_dir;
        p2_kb_nxt   = p2_kb_dir;
        hit_nxt     = 1'b0;
        clash_nxt   = 1'b0;

        if (frame_tick) begin
            if (p1_stunned) p1_stun_nxt = p1_stun - CNT_ONE;
            if (p2_stunned) p2_stun_nxt = p2_stun - CNT_ONE;
            if (!p1_attack_active) p1_used_nxt = 1'b0;
            if (!p2_attack_active) p2_used_nxt = 1'b0;

            // Reloads below override the decrements above; setting a used flag needs
            // attack_active=1, so it can never collide with the clear.
            if (cand_a && cand_b) begin
                p1_stun_nxt = CLASH_LOAD;
                p2_stun_nxt = CLASH_LOAD;
                p1_used_nxt = 1'b1;
                p2_used_nxt = 1'b1;
                p1_kb_nxt   = p2_facing;
                p2_kb_nxt   = p1_facing;
                clash_nxt   = 1'b1;
            end else if (cand_a) begin
                p2_stun_nxt = STUN_LOAD;
                p2_dmg_nxt  = sat_add(p2_damage, dmg_of(p1_anim_state));
                p2_kb_nxt   = p1_facing;
                p1_used_nxt = 1'b1;
                hit_nxt     = 1'b1;
            end else if (cand_b) begin
                p1_stun_nxt = STUN_LOAD;
                p1_dmg_nxt  = sat_add(p1_damage, dmg_of(p2_anim_state));
                p1_kb_nxt   = p2_facing;
                p2_used_nxt = 1'b1;
                hit_nxt     = 1'b1;
            end
        end
    end

    // Event pulses fall back to 0 on any clock without a resolving tick.
    always_ff @(posedge clk) begin
        if (reset || round_reset) begin
            p1_stun     <= '0;
            p2_stun     <= '0;
            p1_used     <= 1'b0;
            p2_used     <= 1'b0;
            p1_damage   <= '0;
            p2_damage   <= '0;
            p1_kb_dir   <= 1'b0;
            p2_kb_dir   <= 1'b0;
            hit_event   <= 1'b0;
            clash_event <= 1'b0;
        end else begin
            p1_stun     <= p1_stun_nxt;
            p2_stun     <= p2_stun_nxt;
            p1_used     <= p1_used_nxt;
            p2_used     <= p2_used_nxt;
            p1_damage   <= p1_dmg_nxt;
            p2_damage   <= p2_dmg_nxt;
            p1_kb_dir   <= p1_kb_nxt;
            p2_kb_dir   <= p2_kb_nxt;
            hit_event   <= hit_nxt;
            clash_event <= clash_nxt;
        end
    end

    assign p1_hit_stun_active = p1_stunned;
    assign p2_hit_stun_active = p2_stunned;

endmodule

// File: tb/tb_combat_arbiter.sv
// Self-checking bench for combat_arbiter: a vector table fed through a scoreboard queue,
// followed by hand-written multi-tick sequences for stun timing, re-attack and saturation.
module tb_combat_arbiter;

    logic       clk = 1'b0;
    logic       reset, frame_tick, round_reset;
    logic       p1_attack_active, p1_facing, p2_attack_active, p2_facing;
    logic [3:0] p1_anim_state, p2_anim_state;
    logic       p1_hits_p2, p2_hits_p1;
    logic       p1_hit_stun_active, p2_hit_stun_active;
    logic [7:0] p1_damage, p2_damage;
    logic       p1_kb_dir, p2_kb_dir, hit_event, clash_event;

    always #5 clk = ~clk;

    combat_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .frame_tick         (frame_tick),
        .round_reset        (round_reset),
        .p1_attack_active   (p1_attack_active),
        .p1_anim_state      (p1_anim_state),
        .p1_facing          (p1_facing),
        .p2_attack_active   (p2_attack_active),
        .p2_anim_state      (p2_anim_state),
        .p2_facing          (p2_facing),
        .p1_hits_p2         (p1_hits_p2),
        .p2_hits_p1         (p2_hits_p1),
        .p1_hit_stun_active (p1_hit_stun_active),
        .p2_hit_stun_active (p2_hit_stun_active),
        .p1_damage          (p1_damage),
        .p2_damage          (p2_damage),
        .p1_kb_dir          (p1_kb_dir),
        .p2_kb_dir          (p2_kb_dir),
        .hit_event          (hit_event),
        .clash_event        (clash_event)
    );

    typedef struct packed {
        logic       rr, tick;
        logic       a1;
        logic [3:0] an1;
        logic       f1, a2;
        logic [3:0] an2;
        logic       f2, h12, h21;
    } in_t;

    typedef struct packed {
        logic       s1, s2, kb1, kb2, hit, clash;
        logic [7:0] d1, d2;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    out_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t mi(input logic rr, tick, a1, input logic [3:0] an1, input logic f1,
                               input logic a2, input logic [3:0] an2, input logic f2, h12, h21);
        return '{rr: rr, tick: tick, a1: a1, an1: an1, f1: f1,
                 a2: a2, an2: an2, f2: f2, h12: h12, h21: h21};
    endfunction

    function automatic out_t mo(input logic s1, s2, kb1, kb2, hit, clash,
                                input logic [7:0] d1, d2);
        return '{s1: s1, s2: s2, kb1: kb1, kb2: kb2, hit: hit, clash: clash, d1: d1, d2: d2};
    endfunction

    function automatic out_t sample();
        return mo(p1_hit_stun_active, p2_hit_stun_active, p1_kb_dir, p2_kb_dir,
                  hit_event, clash_event, p1_damage, p2_damage);
    endfunction

    task automatic apply(input in_t v);
        round_reset      = v.rr;
        frame_tick       = v.tick;
        p1_attack_active = v.a1;
        p1_anim_state    = v.an1;
        p1_facing        = v.f1;
        p2_attack_active = v.a2;
        p2_anim_state    = v.an2;
        p2_facing        = v.f2;
        p1_hits_p2       = v.h12;
        p2_hits_p1       = v.h21;
    endtask

    task automatic set_p1(input logic a, input logic [3:0] an, input logic f, input logic h);
        p1_attack_active = a; p1_anim_state = an; p1_facing = f; p1_hits_p2 = h;
    endtask

    task automatic set_p2(input logic a, input logic [3:0] an, input logic f, input logic h);
        p2_attack_active = a; p2_anim_state = an; p2_facing = f; p2_hits_p1 = h;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_round_reset();
        set_p1(1'b0, 4'd0, 1'b0, 1'b0);
        set_p2(1'b0, 4'd0, 1'b0, 1'b0);
        round_reset = 1'b1;
        @(posedge clk); #1;
        round_reset = 1'b0;
    endtask

    initial begin
        int   hits, clashes, s1_cnt, s2_cnt, ev, nz, second_at;
        out_t exp_o;

        apply(mi(0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0));
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", 32'(sample()), 32'(mo(0, 0, 0, 0, 0, 0, 8'd0, 8'd0)));

        //              rr tk a1 an1 f1 a2 an2 f2 h12 h21         s1 s2 k1 k2 hit cl d1 d2
        vecs.push_back({mi(1, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 8'd0, 8'd0)});
        vecs.push_back({mi(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 8'd0, 8'd0)});
        vecs.push_back({mi(0, 0, 1, 4'd6, 0, 0, 4'd0, 0, 1, 0), mo(0, 0, 0, 0, 0, 0, 8'd0, 8'd0)});
        vecs.push_back({mi(0, 1, 1, 4'd6, 0, 0, 4'd0, 0, 1, 0), mo(0, 1, 0, 0, 1, 0, 8'd0, 8'd3)});
        vecs.push_back({mi(0, 0, 1, 4'd6, 0, 0, 4'd0, 0, 1, 0), mo(0, 1, 0, 0, 0, 0, 8'd0, 8'd3)});
        vecs.push_back({mi(0, 1, 1, 4'd6, 0, 0, 4'd0, 0, 1, 0), mo(0, 1, 0, 0, 0, 0, 8'd0, 8'd3)});
        vecs.push_back({mi(0, 1, 1, 4'd6, 0, 1, 4'd8, 1, 1, 1), mo(0, 1, 0, 0, 0, 0, 8'd0, 8'd3)});
        vecs.push_back({mi(0, 1, 0, 4'd6, 0, 1, 4'd8, 1, 1, 1), mo(0, 1, 0, 0, 0, 0, 8'd0, 8'd3)});
        vecs.push_back({mi(1, 0, 0, 4'd0, 0, 1, 4'd8, 1, 0, 1), mo(0, 0, 0, 0, 0, 0, 8'd0, 8'd0)});
        vecs.push_back({mi(0, 1, 0, 4'd0, 0, 1, 4'd8, 1, 0, 1), mo(1, 0, 1, 0, 1, 0, 8'd4, 8'd0)});
        vecs.push_back({mi(0, 1, 1, 4'd7, 0, 0, 4'd8, 1, 1, 0), mo(1, 0, 1, 0, 0, 0, 8'd4, 8'd0)});
        vecs.push_back({mi(1, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 8'd0, 8'd0)});
        vecs.push_back({mi(0, 1, 1, 4'd9, 0, 1, 4'd7, 1, 1, 1), mo(1, 1, 1, 0, 0, 1, 8'd0, 8'd0)});
        vecs.push_back({mi(0, 1, 1, 4'd9, 0, 1, 4'd7, 1, 1, 1), mo(1, 1, 1, 0, 0, 0, 8'd0, 8'd0)});

        foreach (vecs[k]) begin
            apply(vecs[k].i);
            sb_q.push_back(vecs[k].o);
            @(posedge clk); #1;
            exp_o = sb_q.pop_front();
            check($sformatf("vec%0d", k), 32'(sample()), 32'(exp_o));
        end
        apply(mi(0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0));

        // Idle ticks after a round reset: nothing moves, no events.
        do_round_reset();
        ev = 0; nz = 0;
        for (int t = 0; t < 5; t++) begin
            do_tick();
            ev += int'(hit_event) + int'(clash_event);
            if (sample() != '0) nz++;
        end
        check("idle_events", 32'(ev), 32'd0);
        check("idle_outputs", 32'(nz), 32'd0);

        // Held side attack lands once; defender stunned for exactly STUN_FRAMES ticks.
        do_round_reset();
        set_p1(1'b1, 4'd7, 1'b1, 1'b1);
        hits = 0; s1_cnt = 0; s2_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            if (t == 10) set_p1(1'b0, 4'd7, 1'b1, 1'b0);
            do_tick();
            hits   += int'(hit_event);
            s1_cnt += int'(p1_hit_stun_active);
            s2_cnt += int'(p2_hit_stun_active);
        end
        check("held_hits", 32'(hits), 32'd1);
        check("held_p2_damage", 32'(p2_damage), 32'd5);
        check("held_p2_kb", 32'(p2_kb_dir), 32'd1);
        check("held_p2_stun_ticks", 32'(s2_cnt), 32'd20);
        check("held_p1_stun_ticks", 32'(s1_cnt), 32'd0);

        // Clash: both stunned for CLASH_FRAMES ticks, no damage.
        do_round_reset();
        set_p1(1'b1, 4'd6, 1'b0, 1'b1);
        set_p2(1'b1, 4'd8, 1'b1, 1'b1);
        hits = 0; clashes = 0; s1_cnt = 0; s2_cnt = 0;
        for (int t = 0; t < 11; t++) begin
            do_tick();
            if (t == 0) begin
                set_p1(1'b0, 4'd0, 1'b0, 1'b0);
                set_p2(1'b0, 4'd0, 1'b0, 1'b0);
            end
            hits    += int'(hit_event);
            clashes += int'(clash_event);
            s1_cnt  += int'(p1_hit_stun_active);
            s2_cnt  += int'(p2_hit_stun_active);
        end
        check("clash_events", 32'(clashes), 32'd1);
        check("clash_no_hit", 32'(hits), 32'd0);
        check("clash_p1_stun_ticks", 32'(s1_cnt), 32'd6);
        check("clash_p2_stun_ticks", 32'(s2_cnt), 32'd6);
        check("clash_damage", 32'({p1_damage, p2_damage}), 32'd0);

        // Re-attack during stun is blocked, including the tick the counter goes 1->0.
        do_round_reset();
        set_p1(1'b1, 4'd9, 1'b1, 1'b1);
        do_tick();
        set_p1(1'b0, 4'd9, 1'b1, 1'b0);
        do_tick();
        set_p1(1'b1, 4'd9, 1'b1, 1'b1);
        second_at = -1;
        for (int t = 2; t < 26; t++) begin
            do_tick();
            if (hit_event && second_at < 0) second_at = t;
        end
        check("reattack_tick", 32'(second_at), 32'd21);
        check("reattack_damage", 32'(p2_damage), 32'd12);

        // Saturation: 42 x 6 + 1 = 253, then one more 6-point hit clamps to 255.
        do_round_reset();
        for (int k = 0; k < 43; k++) begin
            set_p1(1'b1, (k < 42) ? 4'd9 : 4'd0, 1'b1, 1'b1);
            do_tick();
            set_p1(1'b0, 4'd0, 1'b1, 1'b0);
            repeat (20) do_tick();
        end
        check("sat_preload", 32'(p2_damage), 32'd253);
        set_p1(1'b1, 4'd9, 1'b1, 1'b1);
        do_tick();
        check("sat_clamp", 32'(p2_damage), 32'd255);

        // round_reset mid-stun with a tick and live overlaps wins; flags are cleared too.
        do_round_reset();
        set_p1(1'b1, 4'd8, 1'b0, 1'b1);
        do_tick();
        repeat (5) do_tick();
        set_p2(1'b1, 4'd6, 1'b1, 1'b1);
        round_reset = 1'b1;
        frame_tick  = 1'b1;
        @(posedge clk); #1;
        round_reset = 1'b0;
        frame_tick  = 1'b0;
        set_p2(1'b0, 4'd0, 1'b0, 1'b0);
        check("rr_clear", 32'(sample()), 32'd0);
        do_tick();
        check("rr_flag_cleared_hit", 32'(hit_event), 32'd1);
        check("rr_flag_cleared_dmg", 32'(p2_damage), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/combat_arbiter.md
Name: combat_arbiter

Overview:
- Resolves combat between two player attack FSMs. Once per frame it decides whether player 1's attack, player 2's attack, or both connect.
- Owns both players' hit-stun timers and drives each player's hit_stun_active input. Accumulates damage, drives knockback direction, and emits hit and clash event pulses for audio and VFX.
- Sits between the two player attack FSMs and the hitbox-overlap logic.

Parameters:
STUN_FRAMES, 20, frames of stun applied to a defender on a clean hit
CLASH_FRAMES, 6, frames of stun applied to both players on a clash
DMG_W, 8, damage accumulator width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
frame_tick  in  1  one-clk pulse per video frame
round_reset  in  1  synchronous clear of all combat state (new round)
p1_attack_active  in  1  player 1 attack FSM attack_active
p1_anim_state  in  4  player 1 attack anim_state (6 neutral, 7 side, 8 up, 9 down)
p1_facing  in  1  player 1 facing (0 left, 1 right)
p2_attack_active  in  1  player 2 attack_active
p2_anim_state  in  4  player 2 anim_state
p2_facing  in  1  player 2 facing
p1_hits_p2  in  1  player 1 hitbox overlaps player 2 hurtbox
p2_hits_p1  in  1  player 2 hitbox overlaps player 1 hurtbox
p1_hit_stun_active  out  1  player 1 is stunned; feeds player 1 attack FSM
p2_hit_stun_active  out  1  player 2 is stunned
p1_damage  out  DMG_W  player 1 accumulated damage
p2_damage  out  DMG_W  player 2 accumulated damage
p1_kb_dir  out  1  knockback direction for player 1 (0 left, 1 right)
p2_kb_dir  out  1  knockback direction for player 2
hit_event  out  1  one-clk pulse: a clean hit resolved
clash_event  out  1  one-clk pulse: a clash resolved

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: all outputs 0, both stun counters 0, both hit_used flags 0.
- Priority: reset > round_reset > frame_tick. round_reset has the same effect as reset.
- State updates only on clocks where frame_tick=1. Outputs are registered and change on that edge.
- hit_event and clash_event are high for exactly one clk after a resolving tick, otherwise 0.
- Per-player stun counter (width ≥ clog2(max(STUN_FRAMES, CLASH_FRAMES)+1)):
  - hitN_stun_active = (counter != 0).
  - Each tick, a nonzero counter decrements by 1 unless reloaded.
- Hit candidates are evaluated on pre-tick register values:
  - candA = p1_attack_active & p1_hits_p2 & !p1_hit_used & !p1_stunned & !p2_stunned
  - candB is the symmetric term for player 2.
  - A stunned defender is invulnerable, including on the tick where its counter goes 1→0.
- candA & candB (clash):
  - Both counters load CLASH_FRAMES.
  - No damage change.
  - Both hit_used flags set.
  - clash_event=1.
  - kb_dir: p1 gets !p2_facing... specified as p1_kb_dir = p2_facing and p2_kb_dir = p1_facing.
- Exactly one candidate (e.g. candA):
  - Defender counter loads STUN_FRAMES.
  - Defender damage += dmg(p1_anim_state), saturating at all-ones.
  - p2_kb_dir = p1_facing.
  - p1_hit_used set.
  - hit_event=1.
  - Attacker counter and damage are unchanged.
- Neither candidate: counters decrement only; event outputs 0.
- dmg table: 6→3, 7→5, 8→4, 9→6, any other value→1.
- hit_used semantics:
  - At most one landed hit per attack instance.
  - hitN_used clears on any tick where pN_attack_active=0.
  - A flag set on a tick is not cleared on that same tick.
- A reload overrides decrement on the same tick.
- Overlap inputs with attack_active=0 are ignored.
- frame_tick=0: nothing changes, and event outputs go low.
- Combinational path: none from inputs to outputs.

Test Plan:
- reset, then 5 ticks idle -> all outputs 0; hit_event and clash_event never assert.
- p1 attack_active=1, anim_state=7, facing=1, p1_hits_p2=1 held 10 ticks ->
  - exactly one hit_event;
  - p2_damage=5; p2_kb_dir=1;
  - p2_hit_stun_active high for exactly 20 ticks; p1 unstunned.
- Both players attacking with both overlaps on the same tick ->
  - one clash_event, no hit_event;
  - both stunned for 6 ticks; damages unchanged.
- p1 hit lands (anim 9), p1 drops attack_active one tick, re-attacks while p2 still stunned -> no second hit; after p2 stun expires, p1 fresh attack lands; p2_damage=12.
- Preload p2_damage=253 via repeated hits, then apply anim 9 hit -> p2_damage saturates at 255.
- round_reset asserted mid-stun together with frame_tick and a candidate hit -> next clk all counters, damages and flags 0; no event pulse.
